// File: rtl/systolic_pkg.sv
// Shared constants and column packing for the systolic array datapath.
// Column c of a packed row occupies bits [c*width +: width].
package systolic_pkg;

  localparam int unsigned DefNumCol    = 4;
  localparam int unsigned DefPsumWidth = 32;

  function automatic int unsigned col_lsb(input int unsigned col, input int unsigned width);
    return col * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Deskews the bottom PE row's staggered psums into whole rows and buffers them for writeback.
// Define PSUM_DRAIN_RELU_EN to clamp negative columns to zero on the output.
module psum_drain
  import systolic_pkg::*;
#(
  parameter int unsigned NUM_COL    = DefNumCol,
  parameter int unsigned PSUM_WIDTH = DefPsumWidth,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            psum_valid_in,
  input  logic [NUM_COL*PSUM_WIDTH-1:0]   psum_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_COL*PSUM_WIDTH-1:0]   out_row,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            overflow
);

  localparam int unsigned RowW = NUM_COL * PSUM_WIDTH;

  logic [RowW-1:0] aligned_row;
  logic            aligned_valid;
  logic [RowW-1:0] head_row;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic            overflow_q, overflow_d;

  // Column c arrives c cycles late, so it waits NUM_COL-1-c cycles to line up.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    localparam int unsigned Dly = NUM_COL - 1 - c;
    localparam int unsigned Lsb = col_lsb(c, PSUM_WIDTH);
    if (Dly == 0) begin : g_direct
      assign aligned_row[Lsb +: PSUM_WIDTH] = psum_in[Lsb +: PSUM_WIDTH];
    end else begin : g_dly
      logic [PSUM_WIDTH-1:0] dly_q [Dly];
      always_ff @(posedge clk) begin
        dly_q[0] <= psum_in[Lsb +: PSUM_WIDTH];
        for (int i = 1; i < int'(Dly); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
      assign aligned_row[Lsb +: PSUM_WIDTH] = dly_q[Dly-1];
    end
  end

  if (NUM_COL == 1) begin : g_no_vsr
    assign aligned_valid = psum_valid_in;
  end else begin : g_vsr
    localparam int unsigned VldW = NUM_COL - 1;
    logic [VldW-1:0] vsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vsr_q <= '0;
      end else if (flush) begin
        vsr_q <= '0;
      end else begin
        vsr_q <= (vsr_q << 1) | VldW'(psum_valid_in);
      end
    end
    assign aligned_valid = vsr_q[VldW-1];
  end

  assign out_valid = !fifo_empty;
  assign fifo_push = aligned_valid && !flush;
  assign fifo_pop  = out_valid && out_ready && !flush;

  sync_fifo #(
    .WIDTH (RowW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (aligned_row),
    .rdata (head_row),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (flush) begin
      overflow_d = 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  always_comb begin
    out_row = '0;
    if (!fifo_empty) begin
      out_row = head_row;
`ifdef PSUM_DRAIN_RELU_EN
      for (int c = 0; c < int'(NUM_COL); c++) begin
        if (head_row[col_lsb(c, PSUM_WIDTH) + PSUM_WIDTH - 1]) begin
          out_row[col_lsb(c, PSUM_WIDTH) +: PSUM_WIDTH] = '0;
        end
      end
`endif
    end
  end

endmodule
